// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
// Produces sum, carry-out and signed overflow, with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] sum_nx;
    logic             c_q;
    logic             c_nx;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nx;
    logic             busy_nx;
    logic             done_nx;
    logic             cout_nx;
    logic             ovf_nx;
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // One full-adder cell operating on the current LSBs and the carry flop.
    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ c_q;
        bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        c_nx     = c_q;
        cnt_nx   = cnt_q;
        sum_nx   = sum;
        busy_nx  = busy;
        done_nx  = done;
        cout_nx  = cout;
        ovf_nx   = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a;
                    b_nx     = b;
                    c_nx     = cin;
                    cnt_nx   = '0;
                    sum_nx   = '0;
                    cout_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end

            SHIFT: begin
                a_nx   = {1'b0, a_q[WIDTH-1:1]};
                b_nx   = {1'b0, b_q[WIDTH-1:1]};
                sum_nx = {bit_s, sum[WIDTH-1:1]};
                c_nx   = bit_c;
                cnt_nx = cnt_q + CW'(1);
                if (last_bit) begin
                    // c_q is the carry into the MSB on this edge.
                    cout_nx  = bit_c;
                    ovf_nx   = bit_c ^ c_q;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end

            DONE: begin
                done_nx  = 1'b0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end

            default: begin
                done_nx  = 1'b0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sum   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            c_q   <= c_nx;
            cnt_q <= cnt_nx;
            sum   <= sum_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            cout  <= cout_nx;
            ovf   <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one active edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v     = vecs[i];
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        step();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        chk($sformatf("v%0d busy_e0", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d done_e0", i), 32'(done), 32'd0);
        for (int e = 1; e < int'(WIDTH); e++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b1) begin
                chk($sformatf("v%0d busy_done_e%0d", i, e), 32'({busy, done}), 32'b10);
            end
        end
        step();
        chk($sformatf("v%0d done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d busy_at_done", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d sum", i), 32'(sum), 32'(v.sum));
        chk($sformatf("v%0d cout", i), 32'(cout), 32'(v.cout));
        chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(v.ovf));
        step();
        chk($sformatf("v%0d idle_busy_done", i), 32'({busy, done}), 32'b00);
        chk($sformatf("v%0d sum_held", i), 32'({sum, cout, ovf}), 32'({v.sum, v.cout, v.ovf}));
    endtask

    initial begin
        int pulses;
        int last_edge;

        errors = 0;
        checks = 0;

        vecs[0] = '{a: 8'h05, b: 8'h03, cin: 1'b0, sum: 8'h08, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 8'h40, b: 8'h40, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b1;
        @(negedge clk);
        step();
        step();
        chk("reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_no_start", 32'({busy, done, sum, cout, ovf}), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Outputs stay stable in IDLE while inputs wander (last vector: 0x80,0,1).
        for (int k = 0; k < 3; k++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            step();
        end
        chk("idle_hold", 32'({busy, done, sum, cout, ovf}), 32'({2'b00, 8'h80, 1'b0, 1'b1}));

        // Start pulsed at edge 3 of a running 05+03 must be ignored.
        start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; a = 8'h11; b = 8'h22;
        step();
        start = 1'b0;
        pulses = 0;
        for (int e = 4; e < 16; e++) begin
            step();
            if (done) begin
                pulses++;
                chk("ignored_start_edge", 32'(e), 32'd8);
                chk("ignored_start_sum", 32'(sum), 32'h08);
            end
        end
        chk("ignored_start_pulses", 32'(pulses), 32'd1);
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Reset at edge 4 abandons the operation without a done pulse.
        start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midreset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            if (done || busy) pulses++;
        end
        chk("midreset_no_activity", 32'(pulses), 32'd0);

        // Start during reset is not accepted; on the first non-reset edge it is.
        rst = 1'b1; start = 1'b1; a = 8'h0A; b = 8'h0B; cin = 1'b0;
        step();
        chk("start_under_reset", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("start_after_reset", 32'(busy), 32'd1);
        start = 1'b0;
        for (int e = 1; e <= int'(WIDTH); e++) step();
        chk("after_reset_done", 32'(done), 32'd1);
        chk("after_reset_sum", 32'({sum, cout, ovf}), 32'({8'h15, 1'b0, 1'b0}));
        step();

        // Start held high: done every WIDTH+2 edges with the same result.
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        pulses    = 0;
        last_edge = -1;
        for (int e = 0; e < 40; e++) begin
            step();
            if (done) begin
                pulses++;
                chk($sformatf("b2b_sum_%0d", pulses), 32'({sum, cout, ovf}), 32'({8'h46, 1'b0, 1'b0}));
                if (last_edge < 0) chk("b2b_first_edge", 32'(e), 32'd8);
                else chk($sformatf("b2b_period_%0d", pulses), 32'(e - last_edge), 32'(WIDTH + 2));
                last_edge = e;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd4);
        start = 1'b0;
        for (int e = 0; e < 12; e++) step();
        chk("final_idle", 32'({busy, done}), 32'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-003 rst  input  1  reset, synchronous, active-high; clock clk.
REQ-004 start  input  1  request to begin an addition; sampled only while busy=0.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge only.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge only.
REQ-007 cin  input  1  carry-in; captured on the accepting edge only.
REQ-008 busy  output  1  high while an addition is in progress (SHIFT or DONE state).
REQ-009 done  output  1  one-cycle pulse marking sum/cout/ovf valid.
REQ-010 sum  output  WIDTH  result A+B+cin modulo 2^WIDTH; held until the next accepted start.
REQ-011 cout  output  1  carry out of bit WIDTH-1; held with sum.
REQ-012 ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB); held with sum.

Function
REQ-013 FSM states IDLE, SHIFT, DONE, all registered; no other reachable state.
REQ-014 IDLE: start=1 at an edge loads A and B shift registers, loads carry flop from cin, clears bit counter and sum register, clears cout/ovf, and moves to SHIFT.
REQ-015 IDLE: start=0 keeps state and all outputs unchanged.
REQ-016 SHIFT: each edge computes s = A[0]^B[0]^c and c' = majority(A[0],B[0],c); shifts A and B right by one; shifts s into sum MSB, sum right by one; carry flop <= c'; counter increments.
REQ-017 Operands are processed LSB first; exactly WIDTH SHIFT edges per addition.
REQ-018 On the WIDTH-th SHIFT edge: cout <= c'; ovf <= c' XOR carry-into-MSB (carry flop value during that edge); state -> DONE; done <= 1.
REQ-019 DONE lasts exactly one cycle; next edge sets done <= 0 and state -> IDLE.
REQ-020 Latency: start sampled at edge k gives done=1 between edges k+WIDTH and k+WIDTH+1; busy=1 between edges k and k+WIDTH+1.
REQ-021 start during SHIFT or DONE is ignored; it has no effect on operands, counter or state and is not queued.
REQ-022 Back-to-back: start held high through DONE is accepted on the first edge in IDLE, i.e. edge k+WIDTH+2.
REQ-023 sum is partially shifted during SHIFT and valid only when done=1 or afterwards in IDLE; sum, cout and ovf stay stable in IDLE until the next accepted start.
REQ-024 The a, b and cin inputs may change freely after the accepting edge without affecting the result.
REQ-025 Counter width is ceil(log2(WIDTH+1)); counter never wraps within an operation.

Reset
REQ-026 rst=1 at an edge forces state IDLE; busy, done, cout and ovf become 0; sum, operand registers, carry flop and counter become 0.
REQ-027 rst has priority over start and over every state transition, including reset mid-SHIFT or during DONE, which abandons the operation with no done pulse.
REQ-028 First edge with rst=0 behaves as IDLE; start present on that edge is accepted.

Verification
REQ-029 WIDTH=8, a=8'h05, b=8'h03, cin=0, start at edge 0 -> done=1 after edge 8 only, sum=8'h08, cout=0, ovf=0; busy high edges 0..9.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
REQ-031 a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-032 start pulsed with a=8'h11, b=8'h22 at edge 3 of a running 8'h05+8'h03 -> ignored; result 8'h08; a single done pulse.
REQ-033 rst asserted at edge 4 of an addition -> all outputs 0 after edge 4, no done pulse; new start 8'h0A+8'h0B after reset -> sum=8'h15 after 8 edges.
REQ-034 start held high continuously with fixed operands -> done pulses every WIDTH+2 cycles, identical sum each time.
